// File: rtl/mem_fill_pkg.sv
// Shared definitions for the memory fill writer: CSR map, status bit positions,
// FSM states and the beat pattern helpers used by the datapath.
package mem_fill_pkg;

    localparam logic [1:0] REG_START  = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_SEED   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    localparam int ADDR_STEP = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // Every beat is 8 bytes, so the programmed base loses its low three bits.
    function automatic logic [31:0] align_beat(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

    function automatic logic [63:0] pattern_beat(input logic [31:0] lo);
        return {lo + 32'd1, lo};
    endfunction

endpackage

// File: rtl/mem_fill_writer_if.sv
// Bus bundle for the fill writer: the 32-bit CSR slave port, the 64-bit
// Avalon-MM write master port and the interrupt line.
interface mem_fill_writer_if #(
    parameter int ADDR_W = 32
);

    logic              ctrl_write;
    logic [31:0]       ctrl_writedata;
    logic              ctrl_read;
    logic [1:0]        ctrl_address;
    logic [31:0]       ctrl_readdata;
    logic              ctrl_waitrequest;

    logic              master_write;
    logic [63:0]       master_writedata;
    logic [ADDR_W-1:0] master_address;
    logic              master_waitrequest;
    logic              master_burstcount;
    logic [7:0]        master_byteenable;

    logic              irq;

    // The fill writer itself: drives the memory side, answers the CSR side.
    modport master (
        input  ctrl_write,
        input  ctrl_writedata,
        input  ctrl_read,
        input  ctrl_address,
        output ctrl_readdata,
        output ctrl_waitrequest,
        output master_write,
        output master_writedata,
        output master_address,
        input  master_waitrequest,
        output master_burstcount,
        output master_byteenable,
        output irq
    );

    // The surrounding system: CPU on the CSR port, memory on the master port.
    modport slave (
        output ctrl_write,
        output ctrl_writedata,
        output ctrl_read,
        output ctrl_address,
        input  ctrl_readdata,
        input  ctrl_waitrequest,
        input  master_write,
        input  master_writedata,
        input  master_address,
        output master_waitrequest,
        input  master_burstcount,
        input  master_byteenable,
        input  irq
    );

endinterface

// File: rtl/mem_fill_csr.sv
// CSR block of the fill writer: START/SEED registers, the done/irq flag and the
// registered readback mux. Also decodes the COUNT-load and done-clear strobes.
module mem_fill_csr
    import mem_fill_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    input  fill_state_e state,
    input  logic [31:0] count_value,
    input  logic        set_done,
    output logic [31:0] start_value,
    output logic [31:0] seed_value,
    output logic [31:0] readdata,
    output logic        done,
    output logic        waitrequest,
    output logic        count_load,
    output logic        clear_done
);

    logic [31:0] start_q, start_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] readdata_q, readdata_d;
    logic        done_q, done_d;
    logic        waitrequest_q;

    assign count_load = wr_en && (address == REG_COUNT);
    assign clear_done = wr_en && (address == REG_STATUS) && writedata[STATUS_DONE];

    // START and SEED are frozen outside IDLE so the running fill stays coherent.
    always_comb begin
        start_d    = start_q;
        seed_d     = seed_q;
        done_d     = done_q;
        readdata_d = '0;

        if (wr_en && (state == IDLE)) begin
            if (address == REG_START) begin
                start_d = align_beat(writedata);
            end
            if (address == REG_SEED) begin
                seed_d = writedata;
            end
        end

        if (set_done) begin
            done_d = 1'b1;
        end else if (clear_done) begin
            done_d = 1'b0;
        end

        case (address)
            REG_START:  readdata_d = start_q;
            REG_COUNT:  readdata_d = count_value;
            REG_SEED:   readdata_d = seed_q;
            REG_STATUS: readdata_d = {30'd0, done_q, state == FILL};
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q       <= '0;
            seed_q        <= '0;
            readdata_q    <= '0;
            done_q        <= 1'b0;
            waitrequest_q <= 1'b0;
        end else begin
            start_q       <= start_d;
            seed_q        <= seed_d;
            readdata_q    <= readdata_d;
            done_q        <= done_d;
            waitrequest_q <= 1'b0;
        end
    end

    assign start_value = start_q;
    assign seed_value  = seed_q;
    assign readdata    = readdata_q;
    assign done        = done_q;
    assign waitrequest = waitrequest_q;

endmodule

// File: rtl/mem_fill_writer.sv
// Avalon-MM write master that fills a buffer with a deterministic 64-bit
// counting pattern, one single-beat write per accepted transfer, then raises irq.
module mem_fill_writer
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input logic                clk,
    input logic                reset,
    mem_fill_writer_if.master  bus
);

    fill_state_e       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       pat_q, pat_d;

    logic [31:0] start_value;
    logic [31:0] seed_value;
    logic [31:0] csr_readdata;
    logic        csr_done;
    logic        csr_waitrequest;
    logic        count_load;
    logic        clear_done;
    logic        set_done;
    logic        accept;

    logic unused_ctrl_read;
    assign unused_ctrl_read = bus.ctrl_read;

    mem_fill_csr u_csr (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (bus.ctrl_write),
        .address     (bus.ctrl_address),
        .writedata   (bus.ctrl_writedata),
        .state       (state_q),
        .count_value (32'(count_q)),
        .set_done    (set_done),
        .start_value (start_value),
        .seed_value  (seed_value),
        .readdata    (csr_readdata),
        .done        (csr_done),
        .waitrequest (csr_waitrequest),
        .count_load  (count_load),
        .clear_done  (clear_done)
    );

    assign accept = (state_q == FILL) && !bus.master_waitrequest;

    // pat_q holds the low half of the current beat (SEED + 2i), so the pattern
    // advances by two per accepted beat and never needs a multiplier.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        pat_d    = pat_q;
        set_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_load) begin
                    count_d = CNT_W'(bus.ctrl_writedata);
                    addr_d  = ADDR_W'(start_value);
                    pat_d   = seed_value;
                    if (CNT_W'(bus.ctrl_writedata) == '0) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                    pat_d   = pat_q + 32'd2;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end
                end
            end
            DONE: begin
                if (clear_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
        end
    end

    // master_write comes straight from the state flop so reset kills it at once.
    assign bus.master_write      = (state_q == FILL);
    assign bus.master_writedata  = (state_q == FILL) ? pattern_beat(pat_q) : '0;
    assign bus.master_address    = addr_q;
    assign bus.master_burstcount = 1'b1;
    assign bus.master_byteenable = 8'hFF;
    assign bus.ctrl_readdata     = csr_readdata;
    assign bus.ctrl_waitrequest  = csr_waitrequest;
    assign bus.irq               = csr_done;

endmodule
